// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. It merges load-use hazards, taken branches and
// the multi-cycle EX unit handshake into stage enables, and keeps saturating performance counters.
module pipeline_stall_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 32,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             mc_req,
  input  logic             mc_done,
  output logic             mc_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             if_flush,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);
  localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMcWait = 2'd1,
    StFlush  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [FlushW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_perf_q;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    if_flush     = 1'b0;
    mc_start     = 1'b0;
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      StRun: begin
        if (branch_taken) begin
          if_flush     = 1'b1;
          id_ex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = StFlush;
            flush_cnt_d = FlushW'(FLUSH_CYCLES - 1);
          end
        end else if (mc_req) begin
          mc_start    = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_hold     = 1'b1;
          state_d     = StMcWait;
          wait_cnt_d  = WaitW'(1);
        end else if (load_use_hazard) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end

      // EX is frozen here, so branch and load-use inputs are stale and ignored.
      StMcWait: begin
        if (mc_done) begin
          state_d = StRun;
        end else if (wait_cnt_q == WaitW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = StRun;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_hold     = 1'b1;
          wait_cnt_d  = wait_cnt_q + WaitW'(1);
        end
      end

      StFlush: begin
        if_flush     = 1'b1;
        id_ex_bubble = 1'b1;
        if (branch_taken) begin
          flush_cnt_d = FlushW'(FLUSH_CYCLES - 1);
        end else if (flush_cnt_q == FlushW'(1)) begin
          state_d = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q - FlushW'(1);
        end
      end

      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Performance counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_perf_q <= '0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (if_flush && (flush_perf_q != '1)) begin
        flush_perf_q <= flush_perf_q + CNT_W'(1);
      end
    end
  end

  assign mc_timeout  = timeout_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_perf_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a FLUSH_CYCLES=3 instance for the main sequences
// and a FLUSH_CYCLES=1, CNT_W=4 instance sharing the inputs for the single-cycle flush and saturation.
module tb_pipeline_stall_controller;

  logic        clk;
  logic        rst_n;
  logic        load_use_hazard;
  logic        branch_taken;
  logic        mc_req;
  logic        mc_done;

  logic        mc_start, pc_write, if_id_write, id_ex_bubble, ex_hold, if_flush, mc_timeout;
  logic [15:0] stall_count, flush_count;
  logic [1:0]  state;

  logic        s_mc_start, s_pc_write, s_if_id_write, s_id_ex_bubble, s_ex_hold, s_if_flush;
  logic        s_mc_timeout;
  logic [3:0]  s_stall_count, s_flush_count;
  logic [1:0]  s_state;

  int checks;
  int errors;

  pipeline_stall_controller #(
    .FLUSH_CYCLES(3),
    .TIMEOUT     (32),
    .CNT_W       (16)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_use_hazard(load_use_hazard),
    .branch_taken   (branch_taken),
    .mc_req         (mc_req),
    .mc_done        (mc_done),
    .mc_start       (mc_start),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_bubble   (id_ex_bubble),
    .ex_hold        (ex_hold),
    .if_flush       (if_flush),
    .mc_timeout     (mc_timeout),
    .stall_count    (stall_count),
    .flush_count    (flush_count),
    .state          (state)
  );

  pipeline_stall_controller #(
    .FLUSH_CYCLES(1),
    .TIMEOUT     (32),
    .CNT_W       (4)
  ) u_small (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_use_hazard(load_use_hazard),
    .branch_taken   (branch_taken),
    .mc_req         (mc_req),
    .mc_done        (mc_done),
    .mc_start       (s_mc_start),
    .pc_write       (s_pc_write),
    .if_id_write    (s_if_id_write),
    .id_ex_bubble   (s_id_ex_bubble),
    .ex_hold        (s_ex_hold),
    .if_flush       (s_if_flush),
    .mc_timeout     (s_mc_timeout),
    .stall_count    (s_stall_count),
    .flush_count    (s_flush_count),
    .state          (s_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    load_use_hazard = 1'b0;
    branch_taken    = 1'b0;
    mc_req          = 1'b0;
    mc_done         = 1'b0;

    #1;
    chk("rst_pc_write", 32'(pc_write), 1);
    chk("rst_if_id_write", 32'(if_id_write), 1);
    chk("rst_ex_hold", 32'(ex_hold), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle for five cycles.
    repeat (5) @(negedge clk);
    #1;
    chk("idle_pc_write", 32'(pc_write), 1);
    chk("idle_if_id_write", 32'(if_id_write), 1);
    chk("idle_state", 32'(state), 0);
    chk("idle_stall_count", 32'(stall_count), 0);
    chk("idle_flush_count", 32'(flush_count), 0);

    // Single load-use stall.
    load_use_hazard = 1'b1;
    #1;
    chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_if_id_write", 32'(if_id_write), 0);
    chk("lu_bubble", 32'(id_ex_bubble), 1);
    @(negedge clk);
    load_use_hazard = 1'b0;
    #1;
    chk("lu_after_pc_write", 32'(pc_write), 1);
    chk("lu_after_bubble", 32'(id_ex_bubble), 0);
    chk("lu_stall_count", 32'(stall_count), 1);

    // Branch wins over a same-cycle load-use hazard; flush lasts 3 cycles.
    branch_taken    = 1'b1;
    load_use_hazard = 1'b1;
    #1;
    chk("br_if_flush", 32'(if_flush), 1);
    chk("br_pc_write", 32'(pc_write), 1);
    chk("br_bubble", 32'(id_ex_bubble), 1);
    chk("br_state", 32'(state), 0);
    chk("br_s_if_flush", 32'(s_if_flush), 1);
    chk("br_s_pc_write", 32'(s_pc_write), 1);
    chk("br_s_if_id_write", 32'(s_if_id_write), 1);
    chk("br_s_bubble", 32'(s_id_ex_bubble), 1);
    chk("br_s_ex_hold", 32'(s_ex_hold), 0);
    chk("br_s_mc_start", 32'(s_mc_start), 0);
    @(negedge clk);
    branch_taken    = 1'b0;
    load_use_hazard = 1'b0;
    #1;
    chk("fl1_state", 32'(state), 2);
    chk("fl1_if_flush", 32'(if_flush), 1);
    chk("fl1_s_state", 32'(s_state), 0);
    chk("fl1_s_if_flush", 32'(s_if_flush), 0);
    @(negedge clk);
    #1;
    chk("fl2_state", 32'(state), 2);
    chk("fl2_if_flush", 32'(if_flush), 1);
    @(negedge clk);
    #1;
    chk("fl3_state", 32'(state), 0);
    chk("fl3_if_flush", 32'(if_flush), 0);
    chk("fl_flush_count", 32'(flush_count), 3);
    chk("fl_stall_count", 32'(stall_count), 1);
    chk("fl_s_flush_count", 32'(s_flush_count), 1);

    // Multi-cycle op completing on the 4th cycle after the request.
    mc_req = 1'b1;
    #1;
    chk("mc_start_pulse", 32'(mc_start), 1);
    chk("mc_ex_hold0", 32'(ex_hold), 1);
    chk("mc_pc_write0", 32'(pc_write), 0);
    @(negedge clk);
    mc_req = 1'b0;
    #1;
    chk("mc_start_single", 32'(mc_start), 0);
    chk("mc_state_wait", 32'(state), 1);
    chk("mc_ex_hold1", 32'(ex_hold), 1);
    repeat (2) @(negedge clk);
    #1;
    chk("mc_ex_hold3", 32'(ex_hold), 1);
    @(negedge clk);
    mc_done = 1'b1;
    #1;
    chk("mc_done_ex_hold", 32'(ex_hold), 0);
    chk("mc_done_pc_write", 32'(pc_write), 1);
    @(negedge clk);
    mc_done = 1'b0;
    #1;
    chk("mc_state_run", 32'(state), 0);
    chk("mc_stall_count", 32'(stall_count), 5);
    chk("mc_no_timeout", 32'(mc_timeout), 0);

    // Multi-cycle op that never completes: forced release at wait count 32.
    mc_req = 1'b1;
    @(negedge clk);
    mc_req = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("to_ex_hold31", 32'(ex_hold), 1);
    chk("to_state31", 32'(state), 1);
    @(negedge clk);
    #1;
    chk("to_release_ex_hold", 32'(ex_hold), 0);
    chk("to_release_pc_write", 32'(pc_write), 1);
    chk("to_flag_not_yet", 32'(mc_timeout), 0);
    @(negedge clk);
    #1;
    chk("to_flag_set", 32'(mc_timeout), 1);
    chk("to_state_run", 32'(state), 0);
    chk("to_stall_count", 32'(stall_count), 37);
    repeat (3) @(negedge clk);
    #1;
    chk("to_flag_sticky", 32'(mc_timeout), 1);

    // Asynchronous reset in the middle of a multi-cycle wait.
    mc_req = 1'b1;
    @(negedge clk);
    mc_req = 1'b0;
    #1;
    chk("ar_pre_state", 32'(state), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pc_write", 32'(pc_write), 1);
    chk("ar_ex_hold", 32'(ex_hold), 0);
    chk("ar_state", 32'(state), 0);
    chk("ar_stall_count", 32'(stall_count), 0);
    chk("ar_flush_count", 32'(flush_count), 0);
    chk("ar_mc_timeout", 32'(mc_timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sustained load-use: the 4-bit counter saturates, the 16-bit one keeps going.
    load_use_hazard = 1'b1;
    #1;
    chk("sat_s_pc_write", 32'(s_pc_write), 0);
    repeat (20) @(negedge clk);
    #1;
    chk("sat_s_stall_count", 32'(s_stall_count), 15);
    chk("sat_stall_count", 32'(stall_count), 20);
    chk("sat_s_mc_timeout", 32'(s_mc_timeout), 0);
    load_use_hazard = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
